blackjack_round_sequencer: RTL and testbench

//  Sequences one Blackjack round: initial deal, player hits/stand, dealer auto-draw, result.

---
 rtl/bj_pkg.sv | 34 +++
 rtl/button_edge.sv | 28 ++
 rtl/blackjack_round_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_blackjack_round_sequencer.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bj_pkg.sv
// Shared encodings for the Blackjack round sequencer: FSM states, result codes, card range.
package bj_pkg;

   typedef enum logic [3:0] {
      ST_IDLE    = 4'd0,
      ST_DEAL_P1 = 4'd1,
      ST_DEAL_D1 = 4'd2,
      ST_DEAL_P2 = 4'd3,
      ST_PLAYER  = 4'd4,
      ST_HIT     = 4'd5,
      ST_DEALER  = 4'd6,
      ST_COMPARE = 4'd7,
      ST_DONE    = 4'd8
   } state_t;

   localparam logic [1:0] RESULT_NONE   = 2'b00;
   localparam logic [1:0] RESULT_PLAYER = 2'b01;
   localparam logic [1:0] RESULT_DEALER = 2'b10;
   localparam logic [1:0] RESULT_PUSH   = 2'b11;

   localparam logic [3:0] CARD_MIN = 4'd1;
   localparam logic [3:0] CARD_MAX = 4'd10;

   // Folds raw source values into the legal 1..10 card range.
   function automatic logic [3:0] clamp_card(input logic [3:0] raw);
      if (raw < CARD_MIN)
         return CARD_MIN;
      else if (raw > CARD_MAX)
         return CARD_MAX;
      else
         return raw;
   endfunction

endpackage

// File: rtl/button_edge.sv
// Synchronises an active-low push-button and emits a one-cycle pulse on each press.
module button_edge (
   input  logic Clock,
   input  logic reset,
   input  logic btn_n,
   output logic press
);

   logic sync0;
   logic sync1;
   logic last;

   // Released level is 1, so reset to 1 to avoid a spurious press after reset.
   always_ff @(posedge Clock) begin
      if (reset) begin
         sync0 <= 1'b1;
         sync1 <= 1'b1;
         last  <= 1'b1;
         press <= 1'b0;
      end else begin
         sync0 <= btn_n;
         sync1 <= sync0;
         last  <= sync1;
         press <= last & ~sync1;
      end
   end

endmodule

// File: rtl/blackjack_round_sequencer.sv
// Registered FSM sequencing one Blackjack round: deal, player hits/stand, dealer draw, result.
module blackjack_round_sequencer
   import bj_pkg::*;
#(
   parameter int unsigned HAND_W       = 5,
   parameter int unsigned TARGET       = 21,
   parameter int unsigned DEALER_STAND = 17
) (
   input  logic              Clock,
   input  logic              reset,
   input  logic              enter_n,
   input  logic              pass_n,
   input  logic              card_valid,
   input  logic [3:0]        card_value,
   output logic              card_req,
   output logic [HAND_W-1:0] phand,
   output logic [HAND_W-1:0] dhand,
   output logic              busy,
   output logic [1:0]        result,
   output logic              result_valid
);

   localparam logic [HAND_W-1:0] TGT      = HAND_W'(TARGET);
   localparam logic [HAND_W-1:0] DSTAND   = HAND_W'(DEALER_STAND);
   localparam logic [HAND_W-1:0] HAND_MAX = '1;

   // Hand accumulation saturates instead of wrapping.
   function automatic logic [HAND_W-1:0] sat_add(input logic [HAND_W-1:0] hand,
                                                 input logic [3:0]        card);
      logic [HAND_W:0] sum;
      sum = {1'b0, hand} + (HAND_W+1)'(card);
      return sum[HAND_W] ? HAND_MAX : sum[HAND_W-1:0];
   endfunction

   state_t            state;
   logic              enter_press;
   logic              pass_press;
   logic [3:0]        card_c;
   logic              accept_c;
   logic [HAND_W-1:0] new_p_c;
   logic [HAND_W-1:0] new_d_c;

   button_edge u_enter (
      .Clock (Clock),
      .reset (reset),
      .btn_n (enter_n),
      .press (enter_press)
   );

   button_edge u_pass (
      .Clock (Clock),
      .reset (reset),
      .btn_n (pass_n),
      .press (pass_press)
   );

   assign card_c   = clamp_card(card_value);
   assign accept_c = card_req & card_valid;
   assign new_p_c  = sat_add(phand, card_c);
   assign new_d_c  = sat_add(dhand, card_c);

   // Draw states raise card_req one cycle after entry and hold it until a card lands.
   always_ff @(posedge Clock) begin
      if (reset) begin
         state        <= ST_IDLE;
         phand        <= '0;
         dhand        <= '0;
         card_req     <= 1'b0;
         busy         <= 1'b0;
         result       <= RESULT_NONE;
         result_valid <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (enter_press) begin
                  state <= ST_DEAL_P1;
                  busy  <= 1'b1;
               end
            end

            ST_DEAL_P1: begin
               if (accept_c) begin
                  phand    <= new_p_c;
                  card_req <= 1'b0;
                  state    <= ST_DEAL_D1;
               end else begin
                  card_req <= 1'b1;
               end
            end

            ST_DEAL_D1: begin
               if (accept_c) begin
                  dhand    <= new_d_c;
                  card_req <= 1'b0;
                  state    <= ST_DEAL_P2;
               end else begin
                  card_req <= 1'b1;
               end
            end

            ST_DEAL_P2: begin
               if (accept_c) begin
                  phand    <= new_p_c;
                  card_req <= 1'b0;
                  state    <= (new_p_c == TGT) ? ST_DEALER : ST_PLAYER;
               end else begin
                  card_req <= 1'b1;
               end
            end

            // A simultaneous stand press is discarded in favour of the hit.
            ST_PLAYER: begin
               if (enter_press)
                  state <= ST_HIT;
               else if (pass_press)
                  state <= ST_DEALER;
            end

            ST_HIT: begin
               if (accept_c) begin
                  phand    <= new_p_c;
                  card_req <= 1'b0;
                  if (new_p_c > TGT) begin
                     state        <= ST_DONE;
                     result       <= RESULT_DEALER;
                     result_valid <= 1'b1;
                     busy         <= 1'b0;
                  end else if (new_p_c == TGT) begin
                     state <= ST_DEALER;
                  end else begin
                     state <= ST_PLAYER;
                  end
               end else begin
                  card_req <= 1'b1;
               end
            end

            // Stand threshold is re-evaluated only between cards.
            ST_DEALER: begin
               if (accept_c) begin
                  dhand    <= new_d_c;
                  card_req <= 1'b0;
               end else if (!card_req) begin
                  if (dhand >= DSTAND)
                     state <= ST_COMPARE;
                  else
                     card_req <= 1'b1;
               end
            end

            ST_COMPARE: begin
               if ((dhand > TGT) || (phand > dhand))
                  result <= RESULT_PLAYER;
               else if (dhand > phand)
                  result <= RESULT_DEALER;
               else
                  result <= RESULT_PUSH;
               result_valid <= 1'b1;
               busy         <= 1'b0;
               state        <= ST_DONE;
            end

            ST_DONE: begin
               if (enter_press) begin
                  phand        <= '0;
                  dhand        <= '0;
                  result       <= RESULT_NONE;
                  result_valid <= 1'b0;
                  busy         <= 1'b1;
                  state        <= ST_DEAL_P1;
               end
            end

            default: begin
               state        <= ST_IDLE;
               card_req     <= 1'b0;
               busy         <= 1'b0;
               result_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_blackjack_round_sequencer.sv
// Directed bench for blackjack_round_sequencer with a game-level reference model checked every cycle.
module tb_blackjack_round_sequencer;

   localparam int TARGET = 21;
   localparam int DSTAND = 17;
   localparam int HMAX   = 31;

   logic       Clock = 1'b0;
   logic       reset;
   logic       enter_n;
   logic       pass_n;
   logic       card_valid;
   logic [3:0] card_value;
   logic       card_req;
   logic [4:0] phand;
   logic [4:0] dhand;
   logic       busy;
   logic [1:0] result;
   logic       result_valid;

   int n_cmp;
   int n_fail;

   // Game-level model: phase 0 idle, 1..3 deal, 4 player, 5 dealer, 6 decided.
   int   m_phase;
   int   m_p;
   int   m_d;
   logic m_decided;
   int   m_res;
   logic m_hit;
   logic m_hold;
   logic req_prev;

   blackjack_round_sequencer dut (
      .Clock        (Clock),
      .reset        (reset),
      .enter_n      (enter_n),
      .pass_n       (pass_n),
      .card_valid   (card_valid),
      .card_value   (card_value),
      .card_req     (card_req),
      .phand        (phand),
      .dhand        (dhand),
      .busy         (busy),
      .result       (result),
      .result_valid (result_valid)
   );

   always #5 Clock = ~Clock;

   initial begin
      #300000;
      $display("FAIL global_timeout: got no finish, expected finish");
      $fatal(1, "bench timeout");
   end

   function automatic int clampv(input int v);
      if (v < 1) return 1;
      if (v > 10) return 10;
      return v;
   endfunction

   function automatic int sat(input int x);
      return (x > HMAX) ? HMAX : x;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_phase = 0; m_p = 0; m_d = 0; m_decided = 1'b0;
      m_res = 0; m_hit = 1'b0; m_hold = 1'b0;
   endtask

   task automatic decide();
      if (m_d > TARGET || m_p > m_d) m_res = 1;
      else if (m_d > m_p) m_res = 2;
      else m_res = 3;
      m_decided = 1'b1;
      m_phase = 6;
   endtask

   task automatic enter_dealer();
      m_phase = 5;
      if (m_d >= DSTAND) decide();
   endtask

   task automatic accept(input int c);
      m_hold = 1'b0;
      case (m_phase)
         1: begin m_p = sat(m_p + c); m_phase = 2; end
         2: begin m_d = sat(m_d + c); m_phase = 3; end
         3: begin
            m_p = sat(m_p + c);
            if (m_p == TARGET) enter_dealer(); else m_phase = 4;
         end
         4: begin
            m_p = sat(m_p + c);
            m_hit = 1'b0;
            if (m_p > TARGET) begin
               m_res = 2; m_decided = 1'b1; m_phase = 6;
            end else if (m_p == TARGET) begin
               enter_dealer();
            end
         end
         5: begin
            m_d = sat(m_d + c);
            if (m_d >= DSTAND) decide();
         end
         default: check("unexpected_card_accept", 1, 0);
      endcase
   endtask

   task automatic check_cycle();
      logic allowed;
      allowed = (m_phase >= 1 && m_phase <= 3) || (m_phase == 4 && m_hit) || (m_phase == 5);
      if (!allowed) check("card_req_unexpected", int'(card_req), 0);
      if (!m_hold) begin
         check("phand", int'(phand), m_p);
         check("dhand", int'(dhand), m_d);
         if (!m_decided) check("result_valid_early", int'(result_valid), 0);
         if (result_valid) begin
            check("result", int'(result), m_res);
            check("busy_in_done", int'(busy), 0);
         end
         if (m_phase >= 1 && m_phase <= 5) check("busy_in_round", int'(busy), 1);
      end
      if (m_phase == 0) check("busy_idle", int'(busy), 0);
   endtask

   // One clock: capture pre-edge inputs, step the model, then compare on the falling edge.
   task automatic tick();
      logic r_s, v_s, q_s;
      logic [3:0] val_s;
      @(posedge Clock);
      r_s = reset; v_s = card_valid; val_s = card_value; q_s = req_prev;
      @(negedge Clock);
      if (r_s) model_reset();
      else if (q_s && v_s) accept(clampv(int'(val_s)));
      check_cycle();
      req_prev = card_req;
   endtask

   task automatic press(input logic en, input logic pa);
      if (en) begin
         if (m_phase == 0 || m_phase == 6) begin
            m_phase = 1; m_p = 0; m_d = 0; m_decided = 1'b0; m_res = 0; m_hold = 1'b1;
         end else if (m_phase == 4) begin
            m_hit = 1'b1;
         end
      end else if (pa && m_phase == 4) begin
         enter_dealer();
      end
      enter_n = ~en;
      pass_n  = ~pa;
      repeat (4) tick();
      enter_n = 1'b1;
      pass_n  = 1'b1;
      repeat (4) tick();
   endtask

   task automatic wait_req();
      int n;
      n = 0;
      while (!card_req && n < 60) begin tick(); n++; end
      if (!card_req) check("card_req_timeout", 0, 1);
   endtask

   task automatic serve_card(input int v, input int lat);
      wait_req();
      if (card_req) begin
         repeat (lat - 1) tick();
         card_value = 4'(v);
         card_valid = 1'b1;
         tick();
         card_valid = 1'b0;
      end
   endtask

   task automatic wait_result(input int exp);
      int n;
      n = 0;
      while (!result_valid && n < 60) begin tick(); n++; end
      check("result_valid_seen", int'(result_valid), 1);
      check("result_literal", int'(result), exp);
      check("model_result", m_res, exp);
   endtask

   initial begin
      n_cmp = 0; n_fail = 0;
      reset = 1'b1; enter_n = 1'b1; pass_n = 1'b1;
      card_valid = 1'b0; card_value = 4'd0;
      req_prev = 1'b0;
      model_reset();

      // Reset state
      repeat (3) tick();
      check("rst_phand", int'(phand), 0);
      check("rst_dhand", int'(dhand), 0);
      check("rst_card_req", int'(card_req), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_result", int'(result), 0);
      check("rst_result_valid", int'(result_valid), 0);
      reset = 1'b0;
      repeat (2) tick();

      // Deal 5,7,9 with 3-cycle card latency
      press(1'b1, 1'b0);
      serve_card(5, 3); serve_card(7, 3); serve_card(9, 3);
      repeat (3) tick();
      check("deal_phand", int'(phand), 14);
      check("deal_dhand", int'(dhand), 7);
      check("deal_busy", int'(busy), 1);
      check("deal_no_req", int'(card_req), 0);

      // Player bust
      press(1'b1, 1'b0);
      serve_card(10, 3);
      wait_result(2);
      check("bust_phand", int'(phand), 24);
      repeat (10) tick();
      check("bust_no_req", int'(card_req), 0);

      // Dealer stands on 18
      press(1'b1, 1'b0);
      serve_card(10, 1); serve_card(7, 1); serve_card(9, 1);
      check("d1_phand", int'(phand), 19);
      press(1'b0, 1'b1);
      serve_card(6, 2); serve_card(5, 2);
      wait_result(1);
      check("d1_dhand", int'(dhand), 18);

      // Dealer busts at 23
      press(1'b1, 1'b0);
      serve_card(10, 1); serve_card(7, 1); serve_card(9, 1);
      press(1'b0, 1'b1);
      serve_card(6, 2); serve_card(10, 2);
      wait_result(1);
      check("d2_dhand", int'(dhand), 23);

      // Push at 18
      press(1'b1, 1'b0);
      serve_card(10, 1); serve_card(8, 1); serve_card(8, 1);
      check("push_dhand_pre", int'(dhand), 8);
      press(1'b0, 1'b1);
      serve_card(10, 3);
      wait_result(3);

      // Simultaneous hit and stand: exactly one hit
      press(1'b1, 1'b0);
      serve_card(2, 1); serve_card(5, 1); serve_card(3, 1);
      press(1'b1, 1'b1);
      serve_card(4, 2);
      repeat (15) tick();
      check("tie_phand", int'(phand), 9);
      check("tie_single_req", int'(card_req), 0);
      press(1'b0, 1'b1);
      serve_card(10, 1); serve_card(2, 1);
      wait_result(2);

      // Clamping of 0 and 13/15
      press(1'b1, 1'b0);
      serve_card(0, 1); serve_card(13, 1); serve_card(15, 1);
      check("clamp_phand", int'(phand), 11);
      check("clamp_dhand", int'(dhand), 10);
      press(1'b0, 1'b1);
      serve_card(7, 1);
      wait_result(2);

      // Auto-stand at 21 after a hit
      press(1'b1, 1'b0);
      serve_card(10, 1); serve_card(4, 1); serve_card(11, 1);
      check("auto_phand20", int'(phand), 20);
      press(1'b1, 1'b0);
      serve_card(1, 2);
      repeat (3) tick();
      check("auto_phand21", int'(phand), 21);
      serve_card(10, 1); serve_card(10, 1);
      wait_result(1);

      // Reset while a hit card is being presented
      press(1'b1, 1'b0);
      serve_card(5, 1); serve_card(6, 1); serve_card(7, 1);
      press(1'b1, 1'b0);
      wait_req();
      card_value = 4'd10; card_valid = 1'b1; reset = 1'b1;
      tick();
      check("mid_rst_phand", int'(phand), 0);
      check("mid_rst_dhand", int'(dhand), 0);
      check("mid_rst_card_req", int'(card_req), 0);
      check("mid_rst_busy", int'(busy), 0);

      // Stray card_valid in IDLE
      reset = 1'b0; card_value = 4'd9;
      repeat (4) tick();
      card_valid = 1'b0;
      tick();
      check("stray_phand", int'(phand), 0);
      check("stray_dhand", int'(dhand), 0);
      check("stray_card_req", int'(card_req), 0);
      check("stray_result_valid", int'(result_valid), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
